// File: rtl/sar_ctrl.sv
// Successive-approximation control for the SAR ADC: sample phase, then one bit trial per CK.
// Latency: START sampled on edge 0 -> DONE strobe after edge TSAMP+NBITS; all outputs registered.
// Backpressure: none; START while BUSY is dropped (no queuing), START in the DONE cycle is accepted.
//
// Ports:
//   CK     clock, rising edge          RN    async active-low reset
//   START  conversion request          CMP   comparator decision (1 = keep trial bit)
//   SAMPLE sample switch enable        DAC   trial code to the cap-DAC, MSB = NBITS-1
//   DOUT   last completed result       BUSY  high in SAMP and CONV
//   DONE   one-cycle strobe, DOUT valid and updated
module sar_ctrl #(
    parameter int NBITS = 8,
    parameter int TSAMP = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic             CMP,
    output logic             SAMPLE,
    output logic [NBITS-1:0] DAC,
    output logic [NBITS-1:0] DOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SAMP = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;

    // Sample counter only needs to reach TSAMP-1; the transition edge is the one after that.
    localparam int CW = (TSAMP > 1) ? $clog2(TSAMP) : 1;
    localparam int KW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(TSAMP - 1);
    localparam logic [KW-1:0] K_MSB    = KW'(NBITS - 1);
    localparam logic [NBITS-1:0] DAC_MID = {1'b1, {(NBITS-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [KW-1:0]    k_q,     k_d;
    logic [NBITS-1:0] dac_q,   dac_d;
    logic [NBITS-1:0] dout_q,  dout_d;
    logic             sample_q, sample_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_SAMP;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    dac_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_SAMP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_CONV;
                    sample_d = 1'b0;
                    dac_d    = DAC_MID;
                    k_d      = K_MSB;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONV: begin
                // Resolve the current trial bit, then raise the next one as the new trial.
                dac_d[k_q] = CMP;
                if (k_q != '0) begin
                    dac_d[k_q - 1'b1] = 1'b1;
                    k_d               = k_q - 1'b1;
                end else begin
                    dout_d  = {dac_q[NBITS-1:1], CMP};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sample_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            dac_q    <= '0;
            dout_q   <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SAMPLE = sample_q;
    assign DAC    = dac_q;
    assign DOUT   = dout_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: a 4-bit/TSAMP=2 instance and an 8-bit/TSAMP=1 instance
// share CK and RN. Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_sar_ctrl;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       CMP = 1'b0;
    logic       SAMPLE, BUSY, DONE;
    logic [3:0] DAC, DOUT;

    logic       START2 = 1'b0;
    logic       CMP2 = 1'b0;
    logic       SAMPLE2, BUSY2, DONE2;
    logic [7:0] DAC2, DOUT2;

    int total = 0;
    int bad   = 0;

    always #5 CK = ~CK;

    sar_ctrl #(.NBITS(4), .TSAMP(2)) dut (
        .CK(CK), .RN(RN), .START(START), .CMP(CMP),
        .SAMPLE(SAMPLE), .DAC(DAC), .DOUT(DOUT), .BUSY(BUSY), .DONE(DONE)
    );

    sar_ctrl #(.NBITS(8), .TSAMP(1)) dut8 (
        .CK(CK), .RN(RN), .START(START2), .CMP(CMP2),
        .SAMPLE(SAMPLE2), .DAC(DAC2), .DOUT(DOUT2), .BUSY(BUSY2), .DONE(DONE2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // One 4-bit conversion; optionally pulses START so that edge 4 (mid-CONV) samples it.
    task automatic run4(input logic [3:0] code, input bit mid_start, input string tag);
        logic [3:0] exp;
        START = 1'b1;
        CMP   = 1'($urandom);
        tick();                                            // edge 0
        START = 1'b0;
        chk({tag, "_e0"}, 32'({SAMPLE, BUSY, DONE, DAC}), 32'(7'b1100000));
        tick();                                            // edge 1
        chk({tag, "_e1"}, 32'({SAMPLE, BUSY, DONE}), 32'(3'b110));
        tick();                                            // edge 2
        exp = 4'b1000;
        chk({tag, "_e2"}, 32'({SAMPLE, BUSY, DONE, DAC}), 32'({3'b010, exp}));
        for (int i = 0; i < 4; i++) begin
            CMP = code[3-i];
            if (mid_start && i == 1) START = 1'b1;
            tick();                                        // edges 3..6
            START = 1'b0;
            exp[3-i] = code[3-i];
            if (i < 3) exp[2-i] = 1'b1;
            chk($sformatf("%s_dac%0d", tag, i + 3), 32'(DAC), 32'(exp));
            chk($sformatf("%s_flags%0d", tag, i + 3), 32'({SAMPLE, BUSY, DONE}),
                32'({1'b0, (i != 3), (i == 3)}));
        end
        chk({tag, "_dout"}, 32'(DOUT), 32'(code));
        CMP = 1'($urandom);
        tick();                                            // edge 7
        chk({tag, "_after"}, 32'({SAMPLE, BUSY, DONE, DAC, DOUT}), 32'({3'b000, code, code}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         done_cnt;
        int         done_at[$];
        logic [7:0] code8;
        logic [7:0] exp8;

        // 1. Reset with random activity on the inputs.
        for (int i = 0; i < 5; i++) begin
            START = 1'($urandom);
            CMP   = 1'($urandom);
            tick();
            chk("rst_hold", 32'({SAMPLE, BUSY, DONE, DAC, DOUT}), 32'(0));
        end
        START = 1'b0;
        RN    = 1'b1;
        tick();
        chk("rst_release", 32'({SAMPLE, BUSY, DONE, DAC, DOUT}), 32'(0));
        tick();
        chk("rst_idle8", 32'({SAMPLE2, BUSY2, DONE2, DAC2, DOUT2}), 32'(0));

        // 2. Basic conversion 1011 (DAC 1000,1100,1010,1011).
        run4(4'b1011, 1'b0, "basic");

        // 3. Extremes.
        run4(4'b0000, 1'b0, "zeros");
        run4(4'b1111, 1'b0, "ones");

        // 4a. START held high: DONE after edges 6, 13, 20 counted from the first accept.
        START = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            CMP = 1'($urandom);
            tick();
            if (DONE) done_at.push_back(i);
        end
        START = 1'b0;
        chk("b2b_count", 32'(done_at.size()), 32'(3));
        if (done_at.size() == 3) begin
            chk("b2b_first", 32'(done_at[0]), 32'(6));
            chk("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'(7));
            chk("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'(7));
        end
        tick();
        chk("b2b_stop", 32'({BUSY, DONE}), 32'(0));

        // 4b. START pulse mid-conversion is dropped and leaves no trace.
        run4(4'b0101, 1'b1, "midstart");
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BUSY || DONE) done_cnt++;
        end
        chk("midstart_quiet", 32'(done_cnt), 32'(0));

        // 5. Async abort just after edge 4.
        START = 1'b1;
        tick();                                            // edge 0
        START = 1'b0;
        CMP   = 1'b1;
        repeat (4) tick();                                 // edges 1..4
        chk("abort_pre", 32'({BUSY, DAC}), 32'({1'b1, 4'b1110}));
        RN = 1'b0;
        #1;
        chk("abort_now", 32'({SAMPLE, BUSY, DONE, DAC, DOUT}), 32'(0));
        #3;
        RN = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DONE || BUSY) done_cnt++;
        end
        chk("abort_nodone", 32'(done_cnt), 32'(0));
        chk("abort_dout", 32'(DOUT), 32'(0));
        run4(4'b0110, 1'b0, "fresh");

        // 6. NBITS=8, TSAMP=1: DONE after edge 9, DOUT = CMP sequence MSB first.
        for (int n = 0; n < 2; n++) begin
            code8  = 8'($urandom_range(0, 255));
            START2 = 1'b1;
            tick();                                        // edge 0
            START2 = 1'b0;
            chk("p8_e0", 32'({SAMPLE2, BUSY2, DAC2}), 32'({2'b11, 8'h00}));
            tick();                                        // edge 1
            chk("p8_e1", 32'({SAMPLE2, BUSY2, DAC2}), 32'({2'b01, 8'h80}));
            exp8 = 8'h80;
            for (int i = 0; i < 8; i++) begin
                CMP2 = code8[7-i];
                tick();                                    // edges 2..9
                exp8[7-i] = code8[7-i];
                if (i < 7) exp8[6-i] = 1'b1;
                chk($sformatf("p8_%0d_dac%0d", n, i + 2), 32'(DAC2), 32'(exp8));
                chk($sformatf("p8_%0d_done%0d", n, i + 2), 32'(DONE2), 32'(i == 7));
            end
            chk($sformatf("p8_%0d_dout", n), 32'(DOUT2), 32'(code8));
            tick();
            chk($sformatf("p8_%0d_clr", n), 32'({BUSY2, DONE2}), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
